id_stage_pipe: RTL and testbench

Registered, parametrised RV32I/RV32E decode stage. It sits between IF/ID and EX and replaces the combinational decoder plus external ID/EX latch. It decodes the instruction, reads the regfile, and resolves operands with two-level forwarding (EX, then MEM). It detects load-use hazards and inserts bubbles, and presents results to EX through a valid/ready-handshaked output register with flush support and a stall counter.

---
 rtl/id_stage_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// Registered RV32I/RV32E decode stage: decode, regfile read, EX/MEM forwarding,
// load-use bubble insertion and a valid/ready output register toward EX.
module id_stage_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RAW  = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] inst_addr_i,
    output logic [RAW-1:0]  reg1_raddr_o,
    output logic [RAW-1:0]  reg2_raddr_o,
    output logic            reg1_re_o,
    output logic            reg2_re_o,
    input  logic [XLEN-1:0] reg1_rdata_i,
    input  logic [XLEN-1:0] reg2_rdata_i,
    input  logic            ex_we_i,
    input  logic [RAW-1:0]  ex_waddr_i,
    input  logic [XLEN-1:0] ex_wdata_i,
    input  logic            ex_is_load_i,
    input  logic            mem_we_i,
    input  logic [RAW-1:0]  mem_waddr_i,
    input  logic [XLEN-1:0] mem_wdata_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_addr_o,
    output logic [XLEN-1:0] op1_o,
    output logic [XLEN-1:0] op2_o,
    output logic            reg_we_o,
    output logic [RAW-1:0]  reg_waddr_o,
    output logic            illegal_o,
    output logic [31:0]     stall_cnt_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [3:0] {
        K_OPIMM, K_OP, K_LUI, K_AUIPC, K_STORE, K_BRANCH, K_LOAD, K_JAL, K_JALR, K_BAD
    } kind_e;

    kind_e           w_kind;
    logic [4:0]      w_rs1_f, w_rs2_f, w_rd_f;
    logic            w_use1, w_use2, w_usew;
    logic            w_bad_idx, w_illegal;
    logic [XLEN-1:0] w_imm_i, w_imm_u;
    logic [XLEN-1:0] w_rs1_val, w_rs2_val;
    logic [XLEN-1:0] w_op1, w_op2;
    logic            w_we_dec;
    logic [RAW-1:0]  w_waddr_dec;
    logic            w_hazard, w_adv, w_xfer;

    // Forwarding priority: x0, then EX, then MEM, then the regfile.
    function automatic logic [XLEN-1:0] resolve(
        input logic [RAW-1:0]  a,
        input logic [XLEN-1:0] rf,
        input logic            ex_we,
        input logic [RAW-1:0]  ex_a,
        input logic [XLEN-1:0] ex_d,
        input logic            mem_we,
        input logic [RAW-1:0]  mem_a,
        input logic [XLEN-1:0] mem_d
    );
        logic [XLEN-1:0] v;
        if (a == {RAW{1'b0}}) begin
            v = {XLEN{1'b0}};
        end else if (ex_we && (ex_a == a)) begin
            v = ex_d;
        end else if (mem_we && (mem_a == a)) begin
            v = mem_d;
        end else begin
            v = rf;
        end
        return v;
    endfunction

    assign w_rs1_f = inst_i[19:15];
    assign w_rs2_f = inst_i[24:20];
    assign w_rd_f  = inst_i[11:7];
    assign w_imm_i = XLEN'($signed(inst_i[31:20]));
    assign w_imm_u = XLEN'($signed({inst_i[31:12], 12'h000}));

    // Opcode classification.
    always_comb begin
        w_kind = K_BAD;
        case (inst_i[6:0])
            7'b0010011: w_kind = K_OPIMM;
            7'b0110011: w_kind = K_OP;
            7'b0110111: w_kind = K_LUI;
            7'b0010111: w_kind = K_AUIPC;
            7'b0100011: w_kind = K_STORE;
            7'b1100011: w_kind = K_BRANCH;
            7'b0000011: w_kind = K_LOAD;
            7'b1101111: w_kind = K_JAL;
            7'b1100111: w_kind = K_JALR;
            default:    w_kind = K_BAD;
        endcase
    end

    // Which register fields each format actually uses.
    always_comb begin
        w_use1 = 1'b0;
        w_use2 = 1'b0;
        w_usew = 1'b0;
        case (w_kind)
            K_OPIMM, K_LOAD, K_JALR: begin w_use1 = 1'b1; w_usew = 1'b1; end
            K_OP:             begin w_use1 = 1'b1; w_use2 = 1'b1; w_usew = 1'b1; end
            K_STORE, K_BRANCH: begin w_use1 = 1'b1; w_use2 = 1'b1; end
            K_LUI, K_AUIPC, K_JAL: w_usew = 1'b1;
            default:          w_usew = 1'b0;
        endcase
    end

    assign w_bad_idx = (w_use1 && (int'(w_rs1_f) >= NREG)) ||
                       (w_use2 && (int'(w_rs2_f) >= NREG)) ||
                       (w_usew && (int'(w_rd_f)  >= NREG));
    assign w_illegal = (w_kind == K_BAD) || w_bad_idx;

    // Illegal instructions read nothing, so they can never trigger a load-use stall.
    assign reg1_re_o    = w_use1 && !w_illegal;
    assign reg2_re_o    = w_use2 && !w_illegal;
    assign reg1_raddr_o = reg1_re_o ? w_rs1_f[RAW-1:0] : {RAW{1'b0}};
    assign reg2_raddr_o = reg2_re_o ? w_rs2_f[RAW-1:0] : {RAW{1'b0}};

    assign w_rs1_val = resolve(reg1_raddr_o, reg1_rdata_i, ex_we_i, ex_waddr_i, ex_wdata_i,
                               mem_we_i, mem_waddr_i, mem_wdata_i);
    assign w_rs2_val = resolve(reg2_raddr_o, reg2_rdata_i, ex_we_i, ex_waddr_i, ex_wdata_i,
                               mem_we_i, mem_waddr_i, mem_wdata_i);

    assign w_hazard = ex_we_i && ex_is_load_i &&
                      ((reg1_re_o && (reg1_raddr_o != {RAW{1'b0}}) && (ex_waddr_i == reg1_raddr_o)) ||
                       (reg2_re_o && (reg2_raddr_o != {RAW{1'b0}}) && (ex_waddr_i == reg2_raddr_o)));

    // Operand selection by format.
    always_comb begin
        w_op1 = {XLEN{1'b0}};
        w_op2 = {XLEN{1'b0}};
        case (w_kind)
            K_OPIMM:                 begin w_op1 = w_rs1_val;   w_op2 = w_imm_i;   end
            K_OP, K_STORE, K_BRANCH: begin w_op1 = w_rs1_val;   w_op2 = w_rs2_val; end
            K_LUI:                   begin w_op1 = w_imm_u;     w_op2 = {XLEN{1'b0}}; end
            K_AUIPC:                 begin w_op1 = inst_addr_i; w_op2 = w_imm_u;   end
            K_LOAD, K_JALR:          begin w_op1 = w_rs1_val;   w_op2 = {XLEN{1'b0}}; end
            default:                 begin w_op1 = {XLEN{1'b0}}; w_op2 = {XLEN{1'b0}}; end
        endcase
    end

    assign w_we_dec    = w_usew && (w_rd_f != 5'd0) && !w_illegal;
    assign w_waddr_dec = w_we_dec ? w_rd_f[RAW-1:0] : {RAW{1'b0}};

    assign w_adv      = !out_valid_o || out_ready_i;
    assign in_ready_o = (w_adv && !w_hazard) || flush_i;
    assign w_xfer     = in_valid_i && in_ready_o && !flush_i;

    // Output register toward EX: flush and idle advance load a bubble, otherwise load or hold.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_o <= 1'b0;
            inst_o      <= NOP;
            inst_addr_o <= {XLEN{1'b0}};
            op1_o       <= {XLEN{1'b0}};
            op2_o       <= {XLEN{1'b0}};
            reg_we_o    <= 1'b0;
            reg_waddr_o <= {RAW{1'b0}};
            illegal_o   <= 1'b0;
        end else if (flush_i || (w_adv && !w_xfer)) begin
            out_valid_o <= 1'b0;
            inst_o      <= NOP;
            inst_addr_o <= {XLEN{1'b0}};
            op1_o       <= {XLEN{1'b0}};
            op2_o       <= {XLEN{1'b0}};
            reg_we_o    <= 1'b0;
            reg_waddr_o <= {RAW{1'b0}};
            illegal_o   <= 1'b0;
        end else if (w_xfer) begin
            out_valid_o <= 1'b1;
            inst_o      <= w_illegal ? NOP : inst_i;
            inst_addr_o <= inst_addr_i;
            op1_o       <= w_illegal ? {XLEN{1'b0}} : w_op1;
            op2_o       <= w_illegal ? {XLEN{1'b0}} : w_op2;
            reg_we_o    <= w_we_dec;
            reg_waddr_o <= w_waddr_dec;
            illegal_o   <= w_illegal;
        end else begin
            out_valid_o <= out_valid_o;
        end
    end

    // Saturating count of cycles lost to load-use hazards.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= 32'd0;
        end else if (in_valid_i && w_hazard && w_adv && !flush_i &&
                     (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end else begin
            stall_cnt_o <= stall_cnt_o;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed steps plus randomized traffic checked
// against a format-table reference model of the decode stage.
module tb_id_stage_pipe;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RAW  = 5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, in_valid, in_ready, ex_we, ex_is_load, mem_we, flush, out_valid, out_ready;
    logic [31:0]     inst, inst_q, pc, pc_q, rd1, rd2, ex_wdata, mem_wdata, op1, op2, stall_cnt;
    logic [RAW-1:0]  ra1, ra2, ex_waddr, mem_waddr, waddr;
    logic            re1, re2, we, ill;

    id_stage_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .inst_i(inst), .inst_addr_i(pc),
        .reg1_raddr_o(ra1), .reg2_raddr_o(ra2), .reg1_re_o(re1), .reg2_re_o(re2),
        .reg1_rdata_i(rd1), .reg2_rdata_i(rd2),
        .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
        .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
        .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .inst_o(inst_q), .inst_addr_o(pc_q), .op1_o(op1), .op2_o(op2),
        .reg_we_o(we), .reg_waddr_o(waddr), .illegal_o(ill), .stall_cnt_o(stall_cnt)
    );

    // RV32E instance, driven only by its own instruction word.
    logic        e_in_ready, e_re1, e_re2, e_out_valid, e_we, e_ill;
    logic [31:0] e_inst, e_inst_q, e_pc_q, e_op1, e_op2, e_cnt;
    logic [3:0]  e_ra1, e_ra2, e_waddr;
    logic        e_one  = 1'b1;
    logic        e_zero = 1'b0;
    logic [3:0]  e_a0   = 4'd0;
    logic [31:0] e_d0   = 32'd0;

    id_stage_pipe #(.XLEN(XLEN), .NREG(16)) dut_e (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(e_one), .in_ready_o(e_in_ready),
        .inst_i(e_inst), .inst_addr_i(e_d0),
        .reg1_raddr_o(e_ra1), .reg2_raddr_o(e_ra2), .reg1_re_o(e_re1), .reg2_re_o(e_re2),
        .reg1_rdata_i(e_d0), .reg2_rdata_i(e_d0),
        .ex_we_i(e_zero), .ex_waddr_i(e_a0), .ex_wdata_i(e_d0), .ex_is_load_i(e_zero),
        .mem_we_i(e_zero), .mem_waddr_i(e_a0), .mem_wdata_i(e_d0),
        .flush_i(e_zero), .out_valid_o(e_out_valid), .out_ready_i(e_one),
        .inst_o(e_inst_q), .inst_addr_o(e_pc_q), .op1_o(e_op1), .op2_o(e_op2),
        .reg_we_o(e_we), .reg_waddr_o(e_waddr), .illegal_o(e_ill), .stall_cnt_o(e_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model of the output register.
    logic        m_valid, m_we, m_ill;
    logic [31:0] m_inst, m_pc, m_op1, m_op2, m_cnt;
    logic [4:0]  m_wa;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_inst = NOP; m_pc = 32'd0; m_op1 = 32'd0; m_op2 = 32'd0;
        m_we = 1'b0; m_wa = 5'd0; m_ill = 1'b0; m_cnt = 32'd0;
    endtask

    // Format letter from the opcode table; '?' = unknown opcode.
    function automatic byte fmt(input logic [31:0] ins);
        case (ins[6:0])
            7'h13: return "I";
            7'h33: return "R";
            7'h37: return "U";
            7'h17: return "A";
            7'h23: return "S";
            7'h63: return "B";
            7'h03: return "L";
            7'h6f: return "J";
            7'h67: return "K";
            default: return "?";
        endcase
    endfunction

    function automatic logic [31:0] fwd(input int a, input logic [31:0] rf);
        if (a == 0) return 32'd0;
        if (ex_we && int'(ex_waddr) == a) return ex_wdata;
        if (mem_we && int'(mem_waddr) == a) return mem_wdata;
        return rf;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, m_valid);
        chk({tag, "_inst"}, inst_q, m_inst);
        chk({tag, "_op1"}, op1, m_op1);
        chk({tag, "_op2"}, op2, m_op2);
        chk({tag, "_we"}, we, m_we);
        chk({tag, "_ill"}, ill, m_ill);
        chk({tag, "_cnt"}, stall_cnt, m_cnt);
        if (m_valid) chk({tag, "_pc"}, pc_q, m_pc);
        if (m_we) chk({tag, "_wa"}, waddr, m_wa);
    endtask

    // One clock: check combinational outputs, advance the model, check the register.
    task automatic cycle(input string tag);
        byte k;
        bit u1, u2, uw, il, haz, adv, rdy, xfer;
        int a1, a2, rd;
        logic [31:0] v1, v2;
        #1;
        k  = fmt(inst);
        a1 = int'(inst[19:15]); a2 = int'(inst[24:20]); rd = int'(inst[11:7]);
        u1 = k inside {"I", "R", "S", "B", "L", "K"};
        u2 = k inside {"R", "S", "B"};
        uw = k inside {"I", "R", "U", "A", "L", "J", "K"};
        il = (k == "?");
        chk({tag, "_re1"}, re1, u1 && !il);
        chk({tag, "_re2"}, re2, u2 && !il);
        chk({tag, "_ra1"}, ra1, (u1 && !il) ? a1 : 0);
        chk({tag, "_ra2"}, ra2, (u2 && !il) ? a2 : 0);
        haz = ex_we && ex_is_load && !il && int'(ex_waddr) != 0 &&
              ((u1 && a1 == int'(ex_waddr)) || (u2 && a2 == int'(ex_waddr)));
        adv  = !m_valid || out_ready;
        rdy  = (adv && !haz) || flush;
        xfer = in_valid && rdy && !flush;
        chk({tag, "_rdy"}, in_ready, rdy);
        if (in_valid && haz && adv && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (flush || (adv && !xfer)) begin
            m_valid = 1'b0; m_inst = NOP; m_op1 = 32'd0; m_op2 = 32'd0; m_we = 1'b0; m_ill = 1'b0;
        end else if (xfer) begin
            v1 = fwd(a1, rd1); v2 = fwd(a2, rd2);
            m_valid = 1'b1; m_pc = pc; m_ill = il;
            m_we = uw && rd != 0 && !il; m_wa = inst[11:7];
            m_inst = il ? NOP : inst;
            case (k)
                "I":           begin m_op1 = v1; m_op2 = {{20{inst[31]}}, inst[31:20]}; end
                "R", "S", "B": begin m_op1 = v1; m_op2 = v2; end
                "U":           begin m_op1 = {inst[31:12], 12'h000}; m_op2 = 32'd0; end
                "A":           begin m_op1 = pc; m_op2 = {inst[31:12], 12'h000}; end
                "L", "K":      begin m_op1 = v1; m_op2 = 32'd0; end
                default:       begin m_op1 = 32'd0; m_op2 = 32'd0; end
            endcase
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_inst"}, inst_q, NOP);
        chk({tag, "_pc"}, pc_q, 32'd0);
        chk({tag, "_op1"}, op1, 32'd0);
        chk({tag, "_op2"}, op2, 32'd0);
        chk({tag, "_we"}, we, 1'b0);
        chk({tag, "_wa"}, waddr, 5'd0);
        chk({tag, "_ill"}, ill, 1'b0);
        chk({tag, "_cnt"}, stall_cnt, 32'd0);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; inst = NOP; pc = 32'd0; rd1 = 32'd0; rd2 = 32'd0;
        ex_we = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0; ex_is_load = 1'b0;
        mem_we = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'd0; flush = 1'b0; out_ready = 1'b1;
    endtask

    logic [6:0] opc_tab [10] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h23, 7'h63, 7'h03, 7'h6f, 7'h67, 7'h7f};

    initial begin
        idle_inputs();
        e_inst = NOP;
        rst_n  = 1'b0;
        model_reset();
        #12;
        check_reset_state("rst");
        chk("rst_rdy", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,5
        in_valid = 1'b1; inst = 32'h0050_0093; pc = 32'h100;
        cycle("addi");
        chk("addi_valid_c", out_valid, 1'b1);
        chk("addi_op2_c", op2, 32'd5);
        chk("addi_wa_c", waddr, 5'd1);

        // add x3,x1,x2 with EX on x1 and MEM on x2, then both on x1
        inst = 32'h0020_81B3; pc = 32'h104; rd1 = 32'hAA; rd2 = 32'hAA;
        ex_we = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'd7;
        mem_we = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'd9;
        cycle("fwd");
        chk("fwd_op1_c", op1, 32'd7);
        chk("fwd_op2_c", op2, 32'd9);
        mem_waddr = 5'd1;
        cycle("fwd_exwin");
        chk("exwin_op1_c", op1, 32'd7);
        chk("exwin_op2_c", op2, 32'hAA);

        // lw x5 in EX, add x6,x5,x5 presented
        inst = 32'h0052_8333; pc = 32'h108; mem_we = 1'b0;
        ex_we = 1'b1; ex_waddr = 5'd5; ex_is_load = 1'b1;
        #1 chk("lu_rdy_c", in_ready, 1'b0);
        cycle("lu_stall");
        chk("lu_bubble_c", out_valid, 1'b0);
        chk("lu_cnt_c", stall_cnt, 32'd1);
        ex_we = 1'b0; ex_is_load = 1'b0; mem_we = 1'b1; mem_waddr = 5'd5; mem_wdata = 32'h1234;
        cycle("lu_go");
        chk("lu_op1_c", op1, 32'h1234);
        chk("lu_op2_c", op2, 32'h1234);
        mem_we = 1'b0;

        // Backpressure
        inst = 32'h0030_0113; pc = 32'h10C;
        cycle("bp_load");
        out_ready = 1'b0; inst = 32'h0090_0213; pc = 32'h110;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            chk("bp_inst_c", inst_q, 32'h0030_0113);
            chk("bp_op2_c", op2, 32'd3);
        end
        out_ready = 1'b1;
        cycle("bp_drain");
        chk("bp_next_c", inst_q, 32'h0090_0213);

        // Flush with a valid output register and a valid incoming instruction
        flush = 1'b1; out_ready = 1'b0; inst = 32'h0010_0313;
        #1 chk("fl_rdy_c", in_ready, 1'b1);
        cycle("flush");
        chk("fl_valid_c", out_valid, 1'b0);
        chk("fl_inst_c", inst_q, NOP);
        flush = 1'b0; out_ready = 1'b1;

        // RV32E: out-of-range rd, then rd == x0
        e_inst = 32'h0010_0893;
        @(posedge clk); #1;
        chk("e_ill", e_ill, 1'b1);
        chk("e_we", e_we, 1'b0);
        chk("e_inst", e_inst_q, NOP);
        chk("e_valid", e_out_valid, 1'b1);
        @(negedge clk);
        e_inst = 32'h0010_0013;
        @(posedge clk); #1;
        chk("e0_ill", e_ill, 1'b0);
        chk("e0_we", e_we, 1'b0);
        @(negedge clk);
        cycle("sync");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            inst = $urandom;
            inst[6:0]   = opc_tab[$urandom_range(0, 9)];
            inst[11:7]  = 5'($urandom_range(0, 3));
            inst[19:15] = 5'($urandom_range(0, 3));
            inst[24:20] = 5'($urandom_range(0, 3));
            pc = $urandom; rd1 = $urandom; rd2 = $urandom;
            in_valid   = ($urandom_range(0, 4) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            ex_we      = $urandom_range(0, 1) != 0;
            ex_is_load = $urandom_range(0, 1) != 0;
            ex_waddr   = 5'($urandom_range(0, 3));
            ex_wdata   = $urandom;
            mem_we     = $urandom_range(0, 1) != 0;
            mem_waddr  = 5'($urandom_range(0, 3));
            mem_wdata  = $urandom;
            cycle("rnd");
        end

        // Reset in the middle of a stall
        idle_inputs();
        in_valid = 1'b1; inst = 32'h0052_8333;
        cycle("pre");
        ex_we = 1'b1; ex_waddr = 5'd5; ex_is_load = 1'b1;
        cycle("mid_stall");
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_rdy", in_ready, 1'b0);
        ex_we = 1'b0; ex_is_load = 1'b0;
        cycle("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
